// File: rtl/simd_seq_pkg.sv
// Shared types and constants for the SIMD operation sequencer.
package simd_seq_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Address width carried by a tag; must be at least BASE_STRIDE_WIDTH.
    localparam int SEQ_ADDR_W = 32;

    // One in-flight element travelling alongside its operand data.
    typedef struct packed {
        logic                  valid;
        logic                  first;
        logic                  last;
        logic [SEQ_ADDR_W-1:0] addr;
    } seq_tag_t;

    // Compute lane opcodes.
    localparam logic [3:0] ARITH = 4'd0;
    localparam logic [3:0] CALC  = 4'd1;
    localparam logic [3:0] COMP  = 4'd2;
    localparam logic [3:0] CAST  = 4'd3;

endpackage

// File: rtl/simd_stride_agen.sv
// Base/stride running address accumulator: load base, then add stride per step.
module simd_stride_agen #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] base,
    input  logic [W-1:0] stride,
    output logic [W-1:0] addr
);

    logic [W-1:0] acc_q;
    logic [W-1:0] stride_q;

    // Load on command accept, otherwise advance by the stride (wraps naturally).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            stride_q <= '0;
        end else if (load) begin
            acc_q    <= base;
            stride_q <= stride;
        end else if (step) begin
            acc_q    <= acc_q + stride_q;
        end
    end

    assign addr = acc_q;

endmodule

// File: rtl/simd_op_sequencer.sv
// Sequences one SIMD lane through a single vector instruction: strided operand
// reads, lane control aligned to returning data, and result write-back.
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready; the
// initiator holds cmd_valid and the fields stable until that cycle.
module simd_op_sequencer
    import simd_seq_pkg::*;
#(
    parameter int OPCODE_BITS       = 4,
    parameter int FUNCTION_BITS     = 4,
    parameter int BASE_STRIDE_WIDTH = 32,
    parameter int ITER_WIDTH        = 16,
    parameter int RD_LATENCY        = 1,
    parameter int CU_LATENCY        = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [OPCODE_BITS-1:0]       cmd_opcode,
    input  logic [FUNCTION_BITS-1:0]     cmd_fn,
    input  logic [ITER_WIDTH-1:0]        cmd_num_iter,
    input  logic [BASE_STRIDE_WIDTH-1:0] cmd_src0_base,
    input  logic [BASE_STRIDE_WIDTH-1:0] cmd_src0_stride,
    input  logic [BASE_STRIDE_WIDTH-1:0] cmd_src1_base,
    input  logic [BASE_STRIDE_WIDTH-1:0] cmd_src1_stride,
    input  logic [BASE_STRIDE_WIDTH-1:0] cmd_dst_base,
    input  logic [BASE_STRIDE_WIDTH-1:0] cmd_dst_stride,
    input  logic                         cmd_reduction,
    input  logic                         cmd_reduction_dim,
    input  logic [7:0]                   cmd_dest_int_bits,
    input  logic [7:0]                   cmd_src1_int_bits,
    input  logic [7:0]                   cmd_src2_int_bits,
    output logic                         rd0_req,
    output logic                         rd1_req,
    output logic [BASE_STRIDE_WIDTH-1:0] rd0_addr,
    output logic [BASE_STRIDE_WIDTH-1:0] rd1_addr,
    output logic [OPCODE_BITS-1:0]       cu_opcode,
    output logic [FUNCTION_BITS-1:0]     cu_fn,
    output logic                         cu_acc_reset,
    output logic                         cu_reduction_flag,
    output logic                         cu_reduction_dim,
    output logic [7:0]                   cu_dest_int_bits,
    output logic [7:0]                   cu_src1_int_bits,
    output logic [7:0]                   cu_src2_int_bits,
    output logic                         wr_req,
    output logic [BASE_STRIDE_WIDTH-1:0] wr_addr,
    output logic                         busy,
    output logic                         done
);

    localparam int DEPTH = RD_LATENCY + CU_LATENCY;

    seq_state_t                   state_q, state_d;
    logic                         accept, issue, last_elem, drain_busy;
    logic [ITER_WIDTH-1:0]        num_q, iter_q;
    logic [2:0]                   gap_q;
    logic                         red_q, dim_q;
    logic [OPCODE_BITS-1:0]       opcode_q;
    logic [FUNCTION_BITS-1:0]     fn_q;
    logic [7:0]                   dest_bits_q, src1_bits_q, src2_bits_q;
    logic [BASE_STRIDE_WIDTH-1:0] dst_addr;
    seq_tag_t                     tag_in;
    seq_tag_t                     pipe_q [DEPTH];

    assign accept    = cmd_valid && (state_q == ST_IDLE);
    // Reductions wait CU_LATENCY cycles between elements so the fed-back result is ready.
    assign issue     = (state_q == ST_ISSUE) && (gap_q == 3'd0);
    assign last_elem = (iter_q == num_q - ITER_WIDTH'(1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DRAIN ends once only the oldest stage can still hold a tag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (cmd_num_iter == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (issue && last_elem) state_d = ST_DRAIN;
            ST_DRAIN: if (!drain_busy) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Command configuration, held until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_q       <= '0;
            red_q       <= 1'b0;
            dim_q       <= 1'b0;
            opcode_q    <= '0;
            fn_q        <= '0;
            dest_bits_q <= '0;
            src1_bits_q <= '0;
            src2_bits_q <= '0;
        end else if (accept) begin
            num_q       <= cmd_num_iter;
            red_q       <= cmd_reduction;
            dim_q       <= cmd_reduction_dim;
            opcode_q    <= cmd_opcode;
            fn_q        <= cmd_fn;
            dest_bits_q <= cmd_dest_int_bits;
            src1_bits_q <= cmd_src1_int_bits;
            src2_bits_q <= cmd_src2_int_bits;
        end
    end

    // Element index and inter-issue gap counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_q <= '0;
            gap_q  <= '0;
        end else if (accept) begin
            iter_q <= '0;
            gap_q  <= '0;
        end else if (issue) begin
            iter_q <= iter_q + ITER_WIDTH'(1);
            gap_q  <= red_q ? 3'(CU_LATENCY - 1) : 3'd0;
        end else if (gap_q != 3'd0) begin
            gap_q  <= gap_q - 3'd1;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.first = (iter_q == '0);
        tag_in.last  = last_elem;
        tag_in.addr  = SEQ_ADDR_W'(dst_addr);
    end

    // Tag shift register; stage k holds the element issued k+1 cycles ago.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= tag_in;
            for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    // Any tag that will still be in flight after this cycle.
    always_comb begin
        drain_busy = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) drain_busy = drain_busy | pipe_q[k].valid;
    end

    simd_stride_agen #(.W(BASE_STRIDE_WIDTH)) u_agen_src0 (
        .clk(clk), .reset(reset), .load(accept), .step(issue),
        .base(cmd_src0_base), .stride(cmd_src0_stride), .addr(rd0_addr)
    );

    simd_stride_agen #(.W(BASE_STRIDE_WIDTH)) u_agen_src1 (
        .clk(clk), .reset(reset), .load(accept), .step(issue),
        .base(cmd_src1_base), .stride(cmd_src1_stride), .addr(rd1_addr)
    );

    // Reductions never step the destination, so their single write lands on dst_base.
    simd_stride_agen #(.W(BASE_STRIDE_WIDTH)) u_agen_dst (
        .clk(clk), .reset(reset), .load(accept), .step(issue && !red_q),
        .base(cmd_dst_base), .stride(cmd_dst_stride), .addr(dst_addr)
    );

    assign cmd_ready         = (state_q == ST_IDLE);
    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);
    assign rd0_req           = issue;
    assign rd1_req           = issue;
    assign cu_opcode         = opcode_q;
    assign cu_fn             = fn_q;
    assign cu_reduction_dim  = dim_q;
    assign cu_dest_int_bits  = dest_bits_q;
    assign cu_src1_int_bits  = src1_bits_q;
    assign cu_src2_int_bits  = src2_bits_q;
    assign cu_acc_reset      = pipe_q[RD_LATENCY-1].valid && pipe_q[RD_LATENCY-1].first;
    assign cu_reduction_flag = pipe_q[RD_LATENCY-1].valid && red_q && !pipe_q[RD_LATENCY-1].first;
    assign wr_req            = pipe_q[DEPTH-1].valid && (!red_q || pipe_q[DEPTH-1].last);
    assign wr_addr           = BASE_STRIDE_WIDTH'(pipe_q[DEPTH-1].addr);

endmodule

// File: tb/tb_simd_op_sequencer.sv
// Directed bench for simd_op_sequencer with RD_LATENCY=1, CU_LATENCY=2
// (write-back lands 3 cycles after a read issue).
module tb_simd_op_sequencer;
    import simd_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = '0;
    logic [3:0]  cmd_fn = '0;
    logic [15:0] cmd_num_iter = '0;
    logic [31:0] cmd_src0_base = '0, cmd_src0_stride = '0;
    logic [31:0] cmd_src1_base = '0, cmd_src1_stride = '0;
    logic [31:0] cmd_dst_base = '0, cmd_dst_stride = '0;
    logic        cmd_reduction = 1'b0, cmd_reduction_dim = 1'b0;
    logic [7:0]  cmd_dest_int_bits = '0, cmd_src1_int_bits = '0, cmd_src2_int_bits = '0;
    logic        rd0_req, rd1_req;
    logic [31:0] rd0_addr, rd1_addr;
    logic [3:0]  cu_opcode, cu_fn;
    logic        cu_acc_reset, cu_reduction_flag, cu_reduction_dim;
    logic [7:0]  cu_dest_int_bits, cu_src1_int_bits, cu_src2_int_bits;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    simd_op_sequencer #(
        .OPCODE_BITS(4), .FUNCTION_BITS(4), .BASE_STRIDE_WIDTH(32),
        .ITER_WIDTH(16), .RD_LATENCY(1), .CU_LATENCY(2)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_fn(cmd_fn), .cmd_num_iter(cmd_num_iter),
        .cmd_src0_base(cmd_src0_base), .cmd_src0_stride(cmd_src0_stride),
        .cmd_src1_base(cmd_src1_base), .cmd_src1_stride(cmd_src1_stride),
        .cmd_dst_base(cmd_dst_base), .cmd_dst_stride(cmd_dst_stride),
        .cmd_reduction(cmd_reduction), .cmd_reduction_dim(cmd_reduction_dim),
        .cmd_dest_int_bits(cmd_dest_int_bits), .cmd_src1_int_bits(cmd_src1_int_bits),
        .cmd_src2_int_bits(cmd_src2_int_bits),
        .rd0_req(rd0_req), .rd1_req(rd1_req), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .cu_opcode(cu_opcode), .cu_fn(cu_fn), .cu_acc_reset(cu_acc_reset),
        .cu_reduction_flag(cu_reduction_flag), .cu_reduction_dim(cu_reduction_dim),
        .cu_dest_int_bits(cu_dest_int_bits), .cu_src1_int_bits(cu_src1_int_bits),
        .cu_src2_int_bits(cu_src2_int_bits),
        .wr_req(wr_req), .wr_addr(wr_addr), .busy(busy), .done(done)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(
        input logic [3:0] op, input logic [3:0] fn, input logic [15:0] n,
        input logic [31:0] s0b, input logic [31:0] s0s,
        input logic [31:0] s1b, input logic [31:0] s1s,
        input logic [31:0] db, input logic [31:0] ds,
        input logic red, input logic dim,
        input logic [7:0] dib, input logic [7:0] s1ib, input logic [7:0] s2ib);
        cmd_opcode = op; cmd_fn = fn; cmd_num_iter = n;
        cmd_src0_base = s0b; cmd_src0_stride = s0s;
        cmd_src1_base = s1b; cmd_src1_stride = s1s;
        cmd_dst_base = db; cmd_dst_stride = ds;
        cmd_reduction = red; cmd_reduction_dim = dim;
        cmd_dest_int_bits = dib; cmd_src1_int_bits = s1ib; cmd_src2_int_bits = s2ib;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd0_req", rd0_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_cu_opcode", cu_opcode, 0);
        chk("rst_rd0_addr", rd0_addr, 0);
        step();
        step();
        reset = 1'b1;
        step();

        // Non-reduction N=4: issues at c=1..4, writes at c=4..7, done at c=8
        chk("t1_ready", cmd_ready, 1);
        set_cmd(COMP, 4'h9, 16'd4, 32'h100, 32'd4, 32'h200, 32'd8, 32'h300, 32'd4,
                1'b0, 1'b0, 8'd4, 8'd6, 8'd2);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk("t1_rd0_req", rd0_req, (c >= 1 && c <= 4));
            chk("t1_rd1_req", rd1_req, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) begin
                chk("t1_rd0_addr", rd0_addr, 32'h100 + 32'(4 * (c - 1)));
                chk("t1_rd1_addr", rd1_addr, 32'h200 + 32'(8 * (c - 1)));
            end
            chk("t1_acc_reset", cu_acc_reset, (c == 2));
            chk("t1_red_flag", cu_reduction_flag, 0);
            chk("t1_wr_req", wr_req, (c >= 4 && c <= 7));
            if (c >= 4 && c <= 7) chk("t1_wr_addr", wr_addr, 32'h300 + 32'(4 * (c - 4)));
            chk("t1_done", done, (c == 8));
            chk("t1_busy", busy, (c <= 8));
            chk("t1_opcode", cu_opcode, COMP);
            chk("t1_fn", cu_fn, 4'h9);
            chk("t1_src1_bits", cu_src1_int_bits, 8'd6);
            step();
        end

        // Reduction N=3: issues at c=1,3,5; flags 0,1,1; single write at c=8 to dst_base
        set_cmd(CALC, 4'h5, 16'd3, 32'h40, 32'd8, 32'h80, 32'h10, 32'h500, 32'd4,
                1'b1, 1'b1, 8'd1, 8'd2, 8'd3);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("t2_rd0_req", rd0_req, (c == 1 || c == 3 || c == 5));
            if (c == 1 || c == 3 || c == 5) begin
                chk("t2_rd0_addr", rd0_addr, 32'h40 + 32'(8 * ((c - 1) / 2)));
                chk("t2_rd1_addr", rd1_addr, 32'h80 + 32'(16 * ((c - 1) / 2)));
            end
            chk("t2_acc_reset", cu_acc_reset, (c == 2));
            chk("t2_red_flag", cu_reduction_flag, (c == 4 || c == 6));
            chk("t2_wr_req", wr_req, (c == 8));
            if (c == 8) chk("t2_wr_addr", wr_addr, 32'h500);
            chk("t2_done", done, (c == 9));
            chk("t2_busy", busy, (c <= 9));
            chk("t2_dim", cu_reduction_dim, 1);
            step();
        end

        // N=0 command with cmd_valid held; second (wrap) command accepted once at c=2
        chk("t3_ready", cmd_ready, 1);
        set_cmd(COMP, 4'h2, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
        cmd_valid = 1'b1;
        step();
        chk("t3_done", done, 1);
        chk("t3_ready_low", cmd_ready, 0);
        chk("t3_busy", busy, 1);
        chk("t3_rd0_req", rd0_req, 0);
        chk("t3_wr_req", wr_req, 0);
        chk("t3_opcode", cu_opcode, COMP);
        chk("t3_dest_bits", cu_dest_int_bits, 8'h11);
        set_cmd(CAST, 4'h7, 16'd2, 32'hFFFF_FFFC, 32'd4, 32'h0, 32'd1, 32'h10, 32'd8,
                1'b0, 1'b0, 8'd1, 8'd2, 8'd3);
        step();
        chk("t3_ready_after_done", cmd_ready, 1);
        chk("t3_done_clear", done, 0);
        chk("t3_opcode_held", cu_opcode, COMP);
        step();
        for (int c = 3; c <= 9; c++) begin
            chk("t4_rd0_req", rd0_req, (c == 3 || c == 4));
            if (c == 3) chk("t4_rd0_addr0", rd0_addr, 32'hFFFF_FFFC);
            if (c == 4) chk("t4_rd0_addr1", rd0_addr, 32'h0000_0000);
            if (c == 3 || c == 4) chk("t4_rd1_addr", rd1_addr, 32'(c - 3));
            chk("t4_wr_req", wr_req, (c == 6 || c == 7));
            if (c == 6 || c == 7) chk("t4_wr_addr", wr_addr, 32'h10 + 32'(8 * (c - 6)));
            chk("t4_done", done, (c == 8));
            chk("t4_ready", cmd_ready, (c == 9));
            chk("t4_busy", busy, (c <= 8));
            chk("t4_opcode", cu_opcode, CAST);
            chk("t4_src2_bits", cu_src2_int_bits, 8'd3);
            if (c == 8) cmd_valid = 1'b0;
            step();
        end

        // Reset during ISSUE of N=8
        set_cmd(ARITH, 4'h1, 16'd8, 32'h1000, 32'd4, 32'h2000, 32'd4, 32'h3000, 32'd4,
                1'b0, 1'b0, 8'd5, 8'd5, 8'd5);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("t5_pre_rd0_req", rd0_req, 1);
        chk("t5_pre_rd0_addr", rd0_addr, 32'h1008);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rd0_req", rd0_req, 0);
        chk("t5_rd0_addr", rd0_addr, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", cmd_ready, 1);
        chk("t5_dest_bits", cu_dest_int_bits, 0);
        chk("t5_acc_reset", cu_acc_reset, 0);
        step();
        step();
        #3;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t5_no_wr", wr_req, 0);
            chk("t5_no_done", done, 0);
            chk("t5_idle_ready", cmd_ready, 1);
            chk("t5_idle_rd", rd0_req, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simd_op_sequencer.md
Name: simd_op_sequencer

Overview:
- Sequences one SIMD compute lane for a single vector instruction.
- Accepts a command, then issues strided operand reads, one per element.
- Drives the compute lane's opcode, function, accumulate and reduction controls so they line up with the returning operand data.
- Generates the write-back strobe and address for each result. For reductions, it writes only the final result.
- Sits between the SIMD instruction decoder and the operand buffers / compute lane.

Parameters:
- OPCODE_BITS, 4, opcode width.
- FUNCTION_BITS, 4, function field width.
- BASE_STRIDE_WIDTH, 32, address/base/stride width.
- ITER_WIDTH, 16, element-count width.
- RD_LATENCY, 1, cycles from rd*_req to operand data at lane inputs (1..4).
- CU_LATENCY, 1, cycles from operands at lane inputs to registered lane output (1..4).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
- cmd_opcode  input  OPCODE_BITS  lane opcode
- cmd_fn  input  FUNCTION_BITS  lane function
- cmd_num_iter  input  ITER_WIDTH  element count N
- cmd_src0_base, cmd_src0_stride, cmd_src1_base, cmd_src1_stride, cmd_dst_base, cmd_dst_stride  input  BASE_STRIDE_WIDTH each  address generation
- cmd_reduction  input  1  reduction command
- cmd_reduction_dim  input  1  feedback operand select (0: input0, 1: input1)
- cmd_dest_int_bits, cmd_src1_int_bits, cmd_src2_int_bits  input  8 each  fixed-point formats
- rd0_req, rd1_req  output  1  operand read strobes
- rd0_addr, rd1_addr  output  BASE_STRIDE_WIDTH  operand addresses
- cu_opcode  output  OPCODE_BITS  lane control
- cu_fn  output  FUNCTION_BITS  lane control
- cu_acc_reset  output  1  lane control
- cu_reduction_flag  output  1  lane control
- cu_reduction_dim  output  1  lane control
- cu_dest_int_bits, cu_src1_int_bits, cu_src2_int_bits  output  8 each  lane formats
- wr_req  output  1  result write strobe
- wr_addr  output  BASE_STRIDE_WIDTH  result address
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse, last write issued

Behaviour:
- Reset (async assert, sync release) clears everything:
  - state=IDLE; all counters and tag pipeline cleared.
  - All outputs 0, except cmd_ready=1.
- Latching: on cmd_valid&&cmd_ready, all cmd_* fields are registered.
  - cu_opcode, cu_fn, cu_reduction_dim and the cu_*_int_bits outputs hold the latched values until the next accept.
- IDLE -> ISSUE on accept when N>0. IDLE -> DONE on accept when N==0 (no reads, no writes).
- ISSUE, element i (0..N-1):
  - rd0_req=rd1_req=1.
  - rd0_addr = src0_base + i*src0_stride, computed by running accumulator, wraps modulo 2^BASE_STRIDE_WIDTH. Same rule for rd1_addr.
  - Non-reduction: one element per cycle.
  - Reduction: one element every CU_LATENCY cycles, so that fed-back data_out is valid. Idle gap cycles have rd*_req=0.
- ISSUE -> DRAIN after issuing element N-1.
- DRAIN -> DONE when the tag pipeline is empty.
- DONE: done=1 for one cycle, then -> IDLE.
- Tag pipeline: a shift register of depth RD_LATENCY+CU_LATENCY carries {valid, first, last, dst_addr} per issued element.
- Control alignment (element issued at cycle t):
  - At t+RD_LATENCY: cu_acc_reset=first.
  - At t+RD_LATENCY: cu_reduction_flag = cmd_reduction && !first, so element 0 takes both operands from the buffers.
  - cu_acc_reset and cu_reduction_flag are 0 when no tag is valid at that stage.
- Write-back, at t+RD_LATENCY+CU_LATENCY:
  - Non-reduction: wr_req=1 for every element; wr_addr = dst_base + i*dst_stride.
  - Reduction: wr_req=1 only for the last element; wr_addr=dst_base.
- Back-to-back commands: cmd_ready is low in ISSUE/DRAIN/DONE, so the next command is accepted no earlier than the cycle after the done pulse.
- N=1 reduction: first=last on the same element. acc_reset=1, reduction_flag=0, single write.
- Reset mid-command: in-flight tags are discarded, no further wr_req, no done pulse.

Decomposition:
- Shared package simd_seq_pkg:
  - state encoding (IDLE, ISSUE, DRAIN, DONE).
  - a tag struct {valid, first, last, addr}.
  - the lane opcode constants ARITH=0, CALC=1, COMP=2, CAST=3.
- One sub-module: simd_stride_agen. It holds the base/stride running accumulator with load and step inputs and is instantiated three times (src0, src1, dst).

Test Plan:
- Non-reduction, N=4, src0 base 0x100 stride 4, dst base 0x300 stride 4, RD_LATENCY=CU_LATENCY=1:
  - rd0_addr 0x100,0x104,0x108,0x10C on consecutive cycles.
  - wr_req on cycles t+2..t+5 with wr_addr 0x300..0x30C.
  - done 1 cycle after the last write.
- Reduction, N=3, CU_LATENCY=2:
  - reads spaced 2 cycles apart.
  - acc_reset only with element 0; reduction_flag 0,1,1.
  - single wr_req to dst_base.
- N=0 command: cmd_ready drops, done pulses, no rd_req/wr_req; next command accepted the cycle after done.
- Address wrap: src0_base 0xFFFFFFFC, stride 4, N=2 -> rd0_addr 0xFFFFFFFC then 0x00000000.
- Reset asserted during ISSUE of N=8: outputs clear asynchronously, no later wr_req/done, cmd_ready=1 after release.
- cmd_valid held high through a command: second command accepted exactly once, after done; cu_* config switches only at the accept.
